// File: rtl/qpl_requester.sv
// -----------------------------------------------------------------------------
// qpl_requester
// PU-side initiator for the QuickPageLite allocation service. It turns a
// simple user command (alloc N bytes / free handle H) into one manager
// transaction at a time. It also keeps a handle table so that users free
// memory by handle only.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-low reset
//   i_cmd_*, o_cmd_rdy        user command stream (op 0 = alloc, 1 = dealloc)
//   o_rsp_*, i_rsp_rdy        user response stream {err, handle, base, lines}
//   o_req_alloc_*             alloc request to manager   {tag, size_bytes}
//   i_rep_alloc_*             alloc reply from manager   {tag, base, lines}
//   o_req_dealloc_*           dealloc request to manager {tag, base, lines}
//   i_rep_dealloc_*           dealloc reply (echo)       {tag, base, lines}
//   o_live_cnt                number of handles currently live
// -----------------------------------------------------------------------------
module qpl_requester #(
    parameter  int LINE_S  = 256,
    parameter  int BLOCK_D = 512,
    parameter  int UDATA_W = 4,
    localparam int BLOCK_W = $clog2(BLOCK_D),
    localparam int SZ_W    = $clog2(BLOCK_D * LINE_S) + 1,
    localparam int REQ_W   = UDATA_W + SZ_W,
    localparam int REP_W   = UDATA_W + 2 * BLOCK_W + 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_vld,
    output logic               o_cmd_rdy,
    input  logic               i_cmd_op,
    input  logic [SZ_W-1:0]    i_cmd_size,
    input  logic [UDATA_W-1:0] i_cmd_handle,
    output logic               o_rsp_vld,
    input  logic               i_rsp_rdy,
    output logic               o_rsp_err,
    output logic [UDATA_W-1:0] o_rsp_handle,
    output logic [BLOCK_W-1:0] o_rsp_base,
    output logic [BLOCK_W:0]   o_rsp_lines,
    output logic               o_req_alloc_vld,
    input  logic               i_req_alloc_rdy,
    output logic [REQ_W-1:0]   o_req_alloc_data,
    input  logic               i_rep_alloc_vld,
    output logic               o_rep_alloc_rdy,
    input  logic [REP_W-1:0]   i_rep_alloc_data,
    output logic               o_req_dealloc_vld,
    input  logic               i_req_dealloc_rdy,
    output logic [REP_W-1:0]   o_req_dealloc_data,
    input  logic               i_rep_dealloc_vld,
    output logic               o_rep_dealloc_rdy,
    input  logic [REP_W-1:0]   i_rep_dealloc_data,
    output logic [UDATA_W:0]   o_live_cnt
);

    localparam int NH = 1 << UDATA_W;
    localparam logic [SZ_W-1:0] MAX_SZ = SZ_W'(BLOCK_D * LINE_S);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        A_REQ  = 3'd1,
        A_WAIT = 3'd2,
        D_REQ  = 3'd3,
        D_WAIT = 3'd4,
        RSP    = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_nextState;

    logic                 r_cmdRdy;
    logic [NH-1:0]        r_live;
    logic [UDATA_W:0]     r_liveCnt;
    logic [UDATA_W-1:0]   r_tag;
    logic [SZ_W-1:0]      r_size;
    logic                 r_rspErr;
    logic [UDATA_W-1:0]   r_rspHandle;
    logic [BLOCK_W-1:0]   r_rspBase;
    logic [BLOCK_W:0]     r_rspLines;
    logic [BLOCK_W-1:0]   r_tabBase  [NH];
    logic [BLOCK_W:0]     r_tabLines [NH];

    logic                 w_accept;
    logic                 w_anyFree;
    logic [UDATA_W-1:0]   w_freeIdx;
    logic                 w_allocBad;
    logic                 w_deallocBad;
    logic [UDATA_W-1:0]   w_aRepTag;
    logic [BLOCK_W-1:0]   w_aRepBase;
    logic [BLOCK_W:0]     w_aRepLines;
    logic                 w_allocOk;
    logic [UDATA_W-1:0]   w_dRepTag;
    logic [BLOCK_W-1:0]   w_dRepBase;
    logic [BLOCK_W:0]     w_dRepLines;
    logic                 w_deallocOk;
    logic                 w_allocDone;
    logic                 w_deallocDone;
    logic [NH-1:0]        w_liveNext;
    logic [UDATA_W:0]     w_liveNextCnt;

    // Reply field split: {tag, base, lines} with lines in the low bits.
    assign w_aRepTag   = i_rep_alloc_data[REP_W-1 -: UDATA_W];
    assign w_aRepBase  = i_rep_alloc_data[2*BLOCK_W -: BLOCK_W];
    assign w_aRepLines = i_rep_alloc_data[BLOCK_W:0];
    assign w_dRepTag   = i_rep_dealloc_data[REP_W-1 -: UDATA_W];
    assign w_dRepBase  = i_rep_dealloc_data[2*BLOCK_W -: BLOCK_W];
    assign w_dRepLines = i_rep_dealloc_data[BLOCK_W:0];

    // o_cmd_rdy is a register so that it reads 0 during reset without any
    // combinational path from i_rst.
    assign w_accept     = i_cmd_vld & r_cmdRdy;
    assign w_anyFree    = ~&r_live;
    assign w_allocBad   = (i_cmd_size == '0) || (i_cmd_size > MAX_SZ) || !w_anyFree;
    assign w_deallocBad = !r_live[i_cmd_handle];
    assign w_allocOk    = (w_aRepTag == r_tag) && (w_aRepLines != '0);
    assign w_deallocOk  = (w_dRepTag == r_tag);
    assign w_allocDone   = (r_state == A_WAIT) && i_rep_alloc_vld;
    assign w_deallocDone = (r_state == D_WAIT) && i_rep_dealloc_vld;

    // Lowest-index free handle. The loop scans downward so the last hit wins.
    always_comb begin
        w_freeIdx = '0;
        for (int i = NH - 1; i >= 0; i--) begin
            if (!r_live[i]) begin
                w_freeIdx = UDATA_W'(i);
            end
        end
    end

    // Next value of the live bits and its popcount. The count register is
    // loaded from this value, so it moves in the same cycle as the bits.
    always_comb begin
        w_liveNext = r_live;
        if (w_allocDone && w_allocOk) begin
            w_liveNext[r_tag] = 1'b1;
        end
        if (w_deallocDone && w_deallocOk) begin
            w_liveNext[r_tag] = 1'b0;
        end
        w_liveNextCnt = '0;
        for (int i = 0; i < NH; i++) begin
            w_liveNextCnt = w_liveNextCnt + (UDATA_W+1)'(w_liveNext[i]);
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and handshake outputs. Every vld/rdy is decoded from
    // the state register only.
    always_comb begin
        w_nextState       = r_state;
        o_req_alloc_vld   = 1'b0;
        o_rep_alloc_rdy   = 1'b0;
        o_req_dealloc_vld = 1'b0;
        o_rep_dealloc_rdy = 1'b0;
        o_rsp_vld         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!i_cmd_op) begin
                        w_nextState = w_allocBad ? RSP : A_REQ;
                    end else begin
                        w_nextState = w_deallocBad ? RSP : D_REQ;
                    end
                end
            end
            A_REQ: begin
                o_req_alloc_vld = 1'b1;
                if (i_req_alloc_rdy) begin
                    w_nextState = A_WAIT;
                end
            end
            A_WAIT: begin
                o_rep_alloc_rdy = 1'b1;
                if (i_rep_alloc_vld) begin
                    w_nextState = RSP;
                end
            end
            D_REQ: begin
                o_req_dealloc_vld = 1'b1;
                if (i_req_dealloc_rdy) begin
                    w_nextState = D_WAIT;
                end
            end
            D_WAIT: begin
                o_rep_dealloc_rdy = 1'b1;
                if (i_rep_dealloc_vld) begin
                    w_nextState = RSP;
                end
            end
            RSP: begin
                o_rsp_vld = 1'b1;
                if (i_rsp_rdy) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Command latch, live tracking and response registers. On accept the
    // response is preset as a failure. Only a good manager reply clears err,
    // so every error path shares the same response values.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cmdRdy    <= 1'b0;
            r_live      <= '0;
            r_liveCnt   <= '0;
            r_tag       <= '0;
            r_size      <= '0;
            r_rspErr    <= 1'b0;
            r_rspHandle <= '0;
            r_rspBase   <= '0;
            r_rspLines  <= '0;
        end else begin
            r_cmdRdy  <= (w_nextState == IDLE);
            r_live    <= w_liveNext;
            r_liveCnt <= w_liveNextCnt;
            if (r_state == IDLE && w_accept) begin
                r_size      <= i_cmd_size;
                r_tag       <= i_cmd_op ? i_cmd_handle : w_freeIdx;
                r_rspHandle <= i_cmd_op ? i_cmd_handle : w_freeIdx;
                r_rspErr    <= 1'b1;
                r_rspBase   <= '0;
                r_rspLines  <= '0;
            end
            if (w_allocDone && w_allocOk) begin
                r_rspErr   <= 1'b0;
                r_rspBase  <= w_aRepBase;
                r_rspLines <= w_aRepLines;
            end
            if (w_deallocDone && w_deallocOk) begin
                r_rspErr   <= 1'b0;
                r_rspBase  <= w_dRepBase;
                r_rspLines <= w_dRepLines;
            end
        end
    end

    // Handle table contents. These are only meaningful where the live bit is
    // set, so they are not reset.
    always_ff @(posedge i_clk) begin
        if (w_allocDone && w_allocOk) begin
            r_tabBase[r_tag]  <= w_aRepBase;
            r_tabLines[r_tag] <= w_aRepLines;
        end
    end

    assign o_cmd_rdy          = r_cmdRdy;
    assign o_rsp_err          = r_rspErr;
    assign o_rsp_handle       = r_rspHandle;
    assign o_rsp_base         = r_rspBase;
    assign o_rsp_lines        = r_rspLines;
    assign o_req_alloc_data   = {r_tag, r_size};
    assign o_req_dealloc_data = {r_tag, r_tabBase[r_tag], r_tabLines[r_tag]};
    assign o_live_cnt         = r_liveCnt;

endmodule
